ultrasonic_scan: RTL and testbench
==================================

# ultrasonic_scan

Multi-channel ultrasonic ranging sequencer for the obstacle-detection front end. It time-multiplexes CHANNELS sensors. For each sensor in turn it issues a fixed-width trigger pulse inside a fixed-length slot, measures the returned echo pulse width in clock cycles, and compares that width against a programmable distance threshold. It sits between the sensor I/O pins and the steering/alarm logic, and supersedes the single-channel fixed-window trigger.

## Interface
Parameters:
- CHANNELS, 4, number of sensors; ≥1
- PERIOD_CYCLES, 6501200, slot length per channel in clk cycles
- TRIG_CYCLES, 1200, trigger pulse width in cycles; 1 ≤ TRIG_CYCLES < PERIOD_CYCLES
- DIST_W, 24, echo-width counter and threshold width

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scanning enable, sampled on clk
- echo  in  CHANNELS  raw asynchronous echo pins, one per sensor
- threshold  in  DIST_W  obstacle threshold in cycles, sampled at publish
- trig  out  CHANNELS  trigger pulses, at most one bit high at a time
- width_valid  out  1  one-cycle strobe: measurement published
- echo_width  out  DIST_W  measured echo high time in cycles, held until next publish
- width_ch  out  $clog2(CHANNELS) (min 1)  channel of the published measurement
- timeout  out  1  published measurement saw no complete echo in the slot
- obstacle  out  CHANNELS  per-channel obstacle flag, held between publishes
- obstacle_any  out  1  OR of obstacle

## Operation
- Echo sync: each echo bit passes through a 2-FF synchronizer to give echo_s. All logic uses only echo_s[ch].
- Slot counter: slot_cnt is CNT_W = $clog2(PERIOD_CYCLES) bits wide. It counts 0..PERIOD_CYCLES-1 in every non-IDLE state.
- IDLE: trig=0 and slot_cnt=0. When enable=1, go to TRIG on the next cycle with the current ch.
- TRIG: trig[ch]=1 while slot_cnt < TRIG_CYCLES, for exactly TRIG_CYCLES cycles. Then go to WAIT_RISE.
- WAIT_RISE:
  - echo_s[ch]=1: go to MEASURE with width=1.
  - slot_cnt==PERIOD_CYCLES-1: publish with timeout=1 and echo_width=0, then advance.
- MEASURE:
  - Each echo_s[ch]=1 cycle increments width, saturating at 2^DIST_W-1.
  - echo_s[ch]=0: publish width with timeout=0 and go to HOLDOFF.
  - Slot end while still high: publish width with timeout=1, then advance.
- HOLDOFF: wait for slot_cnt==PERIOD_CYCLES-1, then advance.
- Advance:
  - ch = (ch==CHANNELS-1) ? 0 : ch+1, and slot_cnt=0.
  - enable=1: go to TRIG. enable=0: go to IDLE.
  - Enable low mid-slot never truncates a trigger or a slot.
- Publish cycle:
  - width_valid=1, width_ch=ch.
  - obstacle[ch] = !timeout && (width < threshold). A timeout clears obstacle[ch]; other channels are unchanged.
- Echo already high on entry to WAIT_RISE (stale echo): counted as the rising edge.

## Timing
- Reset values: trig=0, width_valid=0, echo_width=0, width_ch=0, timeout=0, obstacle=0, obstacle_any=0, state=IDLE, ch=0, slot_cnt=0, synchronizers=0.
- Reset is asynchronous. Asserting it mid-slot drops trig within the same cycle, with no publish.
- Latency: the echo pin edge reaches echo_s 2 cycles later. The reported width equals the pin high time in whole cycles, ±1 for asynchronous sampling.
- Falling edge: width_valid asserts 1 cycle after echo_s falls.
- All outputs are registered. obstacle and obstacle_any update in the same cycle as width_valid.
- First trig rises 1 cycle after enable is sampled high in IDLE.
- Slot-to-slot period is exactly PERIOD_CYCLES cycles while enable stays high.
- Simultaneous slot end and echo fall in MEASURE: the slot end wins, so timeout=1.

## Configuration
- ULTRASONIC_SCAN_FILTER_EN defined:
  - Each channel keeps a 1-bit pending flag.
  - obstacle[ch] sets only after two consecutive below-threshold publishes on that channel.
  - obstacle[ch] clears only after two consecutive non-below publishes; a timeout counts as non-below.
  - Pending flags reset to 0.
- ULTRASONIC_SCAN_FILTER_EN undefined: obstacle[ch] follows each publish directly, as described in Operation.

## Test plan
Bench params: CHANNELS=2, PERIOD_CYCLES=100, TRIG_CYCLES=10, DIST_W=8, threshold=20.
- Reset, enable=1, no echo:
  - trig[0] high for cycles 1–10, trig[1] high for cycles 101–110.
  - width_valid at cycles 100 and 200 with timeout=1, echo_width=0, obstacle=0.
- Echo pulse on channel 0 of 15 cycles starting 5 cycles after trig falls:
  - echo_width=15±1, timeout=0, width_ch=0, obstacle[0]=1, obstacle_any=1.
- Same on channel 0 with a 40-cycle echo:
  - echo_width=40±1, obstacle[0]=0, obstacle[1] unchanged.
- Echo held high past slot end on channel 1:
  - publish at slot end with timeout=1 and obstacle[1]=0.
  - Repeat with DIST_W=4: echo_width saturates at 15.
- enable dropped at cycle 3 of a slot:
  - trig stays high for the full 10 cycles and the slot completes with a publish.
  - Then IDLE with no further trig; rst asserted during a later TRIG clears trig asynchronously.
- With ULTRASONIC_SCAN_FILTER_EN, two 15-cycle echoes on channel 0:
  - obstacle[0]=0 after the first, 1 after the second.
  - A single 40-cycle reading keeps it at 1; a second 40-cycle reading clears it.

Source files
------------

// File: rtl/ultrasonic_scan.sv
// Multi-channel ultrasonic ranging sequencer: round-robin trigger, echo
// width measurement and per-channel obstacle flags against a threshold.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   enable              scanning enable; a started slot always completes
//   echo[CHANNELS]      raw asynchronous echo pins (2-FF synchronised)
//   threshold[DIST_W]   obstacle threshold in cycles, sampled at publish
//   trig[CHANNELS]      one-hot trigger pulses
//   width_valid         one-cycle publish strobe
//   echo_width          measured echo width, held until next publish
//   width_ch            channel of the published measurement
//   timeout             published slot had no complete echo
//   obstacle, obstacle_any  per-channel obstacle flags and their OR
//
// Optional build macro ULTRASONIC_SCAN_FILTER_EN: obstacle flags change only
// after two consecutive publishes agree on the new value.
module ultrasonic_scan #(
    parameter int CHANNELS      = 4,
    parameter int PERIOD_CYCLES = 6501200,
    parameter int TRIG_CYCLES   = 1200,
    parameter int DIST_W        = 24,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] echo,
    input  logic [DIST_W-1:0]   threshold,
    output logic [CHANNELS-1:0] trig,
    output logic                width_valid,
    output logic [DIST_W-1:0]   echo_width,
    output logic [CH_W-1:0]     width_ch,
    output logic                timeout,
    output logic [CHANNELS-1:0] obstacle,
    output logic                obstacle_any
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);

    localparam logic [CNT_W-1:0]    SLOT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);
    localparam logic [DIST_W-1:0]   W_ONE     = DIST_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_n;
    logic [CNT_W-1:0]    slot_cnt;
    logic [CH_W-1:0]     ch;
    logic [DIST_W-1:0]   width;
    logic [DIST_W-1:0]   width_n;
    logic [DIST_W-1:0]   sat_inc;
    logic [CHANNELS-1:0] echo_m;
    logic [CHANNELS-1:0] echo_s;
    logic [CHANNELS-1:0] ch_hot;
    logic [CHANNELS-1:0] obs_n;
    logic                echo_cur;
    logic                slot_end;
    logic                pub;
    logic                pub_to;
    logic [DIST_W-1:0]   pub_w;
    logic                adv;
    logic                below;

`ifdef ULTRASONIC_SCAN_FILTER_EN
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pend_n;
    logic                obs_cur;
    logic                pend_cur;
`endif

    assign ch_hot   = CH_ONE << ch;
    assign echo_cur = |(echo_s & ch_hot);
    assign slot_end = (slot_cnt == SLOT_LAST);
    assign sat_inc  = (&width) ? width : width + W_ONE;

    always_comb begin
        state_n = state;
        width_n = width;
        pub     = 1'b0;
        pub_to  = 1'b0;
        pub_w   = width;
        adv     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_n = S_TRIG;
            end
            S_TRIG: begin
                if (slot_cnt == TRIG_LAST) state_n = S_WAIT;
            end
            S_WAIT: begin
                // Slot end wins over a late rise; a stale high echo counts
                // as the rising edge.
                if (slot_end) begin
                    pub    = 1'b1;
                    pub_to = 1'b1;
                    pub_w  = '0;
                    adv    = 1'b1;
                end else if (echo_cur) begin
                    width_n = W_ONE;
                    state_n = S_MEAS;
                end
            end
            S_MEAS: begin
                // Slot end beats a coincident fall: reported as timeout.
                if (slot_end) begin
                    pub    = 1'b1;
                    pub_to = 1'b1;
                    pub_w  = echo_cur ? sat_inc : width;
                    adv    = 1'b1;
                end else if (echo_cur) begin
                    width_n = sat_inc;
                end else begin
                    pub     = 1'b1;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (slot_end) adv = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (adv) state_n = enable ? S_TRIG : S_IDLE;
    end

    always_comb begin
        below = !pub_to && (pub_w < threshold);
`ifdef ULTRASONIC_SCAN_FILTER_EN
        obs_cur  = |(obstacle & ch_hot);
        pend_cur = |(pending & ch_hot);
        obs_n    = obstacle;
        pend_n   = pending & ~ch_hot;
        if (below != obs_cur) begin
            if (pend_cur) begin
                obs_n = below ? (obstacle | ch_hot) : (obstacle & ~ch_hot);
            end else begin
                pend_n = pending | ch_hot;
            end
        end
`else
        obs_n = below ? (obstacle | ch_hot) : (obstacle & ~ch_hot);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m       <= '0;
            echo_s       <= '0;
            state        <= S_IDLE;
            slot_cnt     <= '0;
            ch           <= '0;
            width        <= '0;
            trig         <= '0;
            width_valid  <= 1'b0;
            echo_width   <= '0;
            width_ch     <= '0;
            timeout      <= 1'b0;
            obstacle     <= '0;
            obstacle_any <= 1'b0;
        end else begin
            echo_m      <= echo;
            echo_s      <= echo_m;
            state       <= state_n;
            width       <= width_n;
            width_valid <= pub;
            trig        <= (state == S_TRIG) ? ch_hot : '0;
            if (state == S_IDLE || slot_end) slot_cnt <= '0;
            else slot_cnt <= slot_cnt + 1'b1;
            if (adv) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            if (pub) begin
                echo_width   <= pub_w;
                width_ch     <= ch;
                timeout      <= pub_to;
                obstacle     <= obs_n;
                obstacle_any <= |obs_n;
            end
        end
    end

`ifdef ULTRASONIC_SCAN_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else if (pub) pending <= pend_n;
    end
`endif

endmodule

// File: tb/tb_ultrasonic_scan.sv
// Scoreboard bench for ultrasonic_scan (2 channels, 100-cycle slots).
// A DIST_W=4 twin shares the stimulus to observe width saturation.
module tb_ultrasonic_scan;

    localparam int PER = 100;
    localparam int THR = 20;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] echo;
    logic [1:0] trig;
    logic       width_valid;
    logic [7:0] echo_width;
    logic       width_ch;
    logic       timeout;
    logic [1:0] obstacle;
    logic       obstacle_any;

    logic [1:0] trig4;
    logic       wv4;
    logic [3:0] ew4;
    logic       wc4;
    logic       to4;
    logic [1:0] ob4;
    logic       oa4;

    ultrasonic_scan #(
        .CHANNELS(2), .PERIOD_CYCLES(PER), .TRIG_CYCLES(10), .DIST_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo),
        .threshold(8'd20), .trig(trig), .width_valid(width_valid),
        .echo_width(echo_width), .width_ch(width_ch), .timeout(timeout),
        .obstacle(obstacle), .obstacle_any(obstacle_any)
    );

    ultrasonic_scan #(
        .CHANNELS(2), .PERIOD_CYCLES(PER), .TRIG_CYCLES(10), .DIST_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo),
        .threshold(4'd10), .trig(trig4), .width_valid(wv4),
        .echo_width(ew4), .width_ch(wc4), .timeout(to4),
        .obstacle(ob4), .obstacle_any(oa4)
    );

    typedef struct {
        int         ch;
        int         to;
        int         w;
        logic [1:0] obs;
        int         at;
        bit         chk4;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    logic [1:0] m_obs;
    logic [1:0] m_pend;
    int         total;
    int         bad;
    int         cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input int c, input int to, input int w,
                        input int at, input bit c4);
        exp_t e;
        bit   bl;
        bl = (to == 0) && (w < THR);
`ifdef ULTRASONIC_SCAN_FILTER_EN
        if (bl != m_obs[c]) begin
            if (m_pend[c]) begin
                m_obs[c]  = bl;
                m_pend[c] = 1'b0;
            end else begin
                m_pend[c] = 1'b1;
            end
        end else begin
            m_pend[c] = 1'b0;
        end
`else
        m_obs[c] = bl;
`endif
        e.ch   = c;
        e.to   = to;
        e.w    = (w > 255) ? 255 : w;
        e.obs  = m_obs;
        e.at   = at;
        e.chk4 = c4;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && width_valid) begin
            if (q.size() == 0) begin
                check("unexpected_pub", 1, 0);
            end else begin
                me = q.pop_front();
                check("pub_cycle", cyc, me.at);
                check("width_ch", int'(width_ch), me.ch);
                check("timeout", int'(timeout), me.to);
                check("echo_width", int'(echo_width), me.w);
                check("obstacle", int'(obstacle), int'(me.obs));
                check("obstacle_any", int'(obstacle_any), int'(|me.obs));
                if (me.chk4) begin
                    check("w4_valid", int'(wv4), 1);
                    check("w4_width_sat", int'(ew4), 15);
                    check("w4_timeout", int'(to4), 1);
                end
            end
        end
    end

    task automatic wait_rise(input int c, output int rise);
        rise = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (trig[c]) begin
                rise = cyc;
                break;
            end
        end
        if (rise < 0) check("trig_rise_wait", 0, 1);
    endtask

    // kind: 0 no echo, 1 pulse of len, 2 echo held past slot end,
    // 3 no echo with enable dropped in the third trigger cycle
    task automatic run_slot(input int c, input int kind, input int len,
                            output int rise);
        int p;
        logic [1:0] hot;
        hot = 2'b01 << c;
        wait_rise(c, rise);
        if (rise < 0) return;
        check("trig_on", int'(trig), int'(hot));
        repeat (2) @(negedge clk);
        if (kind == 3) enable = 1'b0;
        repeat (7) @(negedge clk);
        check("trig_last", int'(trig), int'(hot));
        @(negedge clk);
        check("trig_off", int'(trig), 0);
        if (kind == 0 || kind == 3) begin
            push(c, 1, 0, rise + PER - 1, 1'b0);
            return;
        end
        repeat (5) @(negedge clk);
        p = cyc;
        echo[c] = 1'b1;
        if (kind == 1) begin
            push(c, 0, len, p + len + 3, 1'b0);
            repeat (len) @(negedge clk);
            echo[c] = 1'b0;
        end else begin
            push(c, 1, rise + PER - 3 - p, rise + PER - 1, 1'b1);
            repeat (rise + PER - 1 - p) @(negedge clk);
            echo[c] = 1'b0;
        end
    endtask

    initial begin
        int t_en;
        int r0;
        int r1;
        int r;
        int hi;
        total  = 0;
        bad    = 0;
        m_obs  = '0;
        m_pend = '0;
        rst    = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_valid", int'(width_valid), 0);
        check("rst_width", int'(echo_width), 0);
        check("rst_ch", int'(width_ch), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_obstacle", int'(obstacle), 0);
        check("rst_any", int'(obstacle_any), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_trig", int'(trig), 0);
        enable = 1'b1;
        t_en = cyc;

        run_slot(0, 0, 0, r0);
        check("first_trig_cycle", r0, t_en + 2);
        run_slot(1, 0, 0, r1);
        check("slot_period", r1 - r0, PER);
        run_slot(0, 1, 15, r);
        run_slot(1, 1, 10, r);
        run_slot(0, 1, 15, r);
        run_slot(1, 1, 10, r);
        run_slot(0, 1, 40, r);
        run_slot(1, 2, 0, r);
        run_slot(0, 1, 40, r);
        run_slot(1, 3, 0, r);

        hi = 0;
        repeat (250) begin
            @(negedge clk);
            if (trig != '0) hi++;
        end
        check("idle_no_trig", hi, 0);
        check("sb_drained", q.size(), 0);

        enable = 1'b1;
        wait_rise(0, r);
        repeat (2) @(negedge clk);
        check("trig_pre_rst", int'(trig), 1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check("async_rst_trig", int'(trig), 0);
        check("async_rst_valid", int'(width_valid), 0);
        repeat (3) @(negedge clk);
        check("rst2_obstacle", int'(obstacle), 0);
        check("rst2_width", int'(echo_width), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_trig", int'(trig), 0);
        check("sb_final", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
